// File: rtl/cell_scan_scheduler.sv
// Raster-scan controller: issues 3x3 window origins over a frame and maps in-order results to txImage addresses.
// Latency: first origin one cycle after start; write strobe is combinational with the accepted result.
// Backpressure: origin/op/user held while valid && !ready; issue pauses at MAX_OUT cells in flight.
module cell_scan_scheduler #(
    parameter  int IMG_W    = 640,
    parameter  int IMG_H    = 480,
    parameter  int CELL_N   = 3,
    parameter  int OPCODE_W = 4,
    parameter  int CH_W     = 8,
    parameter  int MAX_OUT  = 4,
    localparam int NX       = IMG_W - CELL_N + 1,
    localparam int NY       = IMG_H - CELL_N + 1,
    localparam int XW       = $clog2(IMG_W),
    localparam int YW       = $clog2(IMG_H),
    localparam int AW       = $clog2(NX * NY)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [CH_W-1:0]     user_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                cell_valid_o,
    input  logic                cell_ready_i,
    output logic [XW-1:0]       cell_x_o,
    output logic [YW-1:0]       cell_y_o,
    output logic [OPCODE_W-1:0] cell_op_o,
    output logic [CH_W-1:0]     cell_user_o,
    input  logic                res_valid_i,
    output logic                res_wr_en_o,
    output logic [AW-1:0]       res_addr_o
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [XW-1:0]       X_LAST  = XW'(NX - 1);
    localparam logic [YW-1:0]       Y_LAST  = YW'(NY - 1);
    localparam logic [OW-1:0]       OUT_MAX = OW'(MAX_OUT);
    // Highest legal opcode (AVG); anything above it is rejected without issuing.
    localparam logic [OPCODE_W-1:0] OP_AVG  = OPCODE_W'(11);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [OW-1:0]         out_q, out_d;
    logic [AW-1:0]         ret_q, ret_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [CH_W-1:0]       user_q, user_d;
    logic                  err_q, err_d;

    logic xfer;
    logic res_acc;

    // Outputs decode straight from flops except the write strobe, which follows the accepted result.
    always_comb begin
        cell_valid_o = (state_q == S_ISSUE) && (out_q < OUT_MAX);
        xfer         = cell_valid_o && cell_ready_i;
        res_acc      = res_valid_i && (out_q != '0);
        busy_o       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done_o       = (state_q == S_DONE);
        err_o        = (state_q == S_DONE) && err_q;
        cell_x_o     = x_q;
        cell_y_o     = y_q;
        cell_op_o    = op_q;
        cell_user_o  = user_q;
        res_wr_en_o  = res_acc;
        res_addr_o   = ret_q;
    end

    // Next-state: frame sequencing, raster advance, in-flight tracking and write address.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        out_d   = out_q;
        ret_d   = ret_q;
        op_d    = op_q;
        user_d  = user_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d   = opcode_i;
                    user_d = user_i;
                    if (opcode_i > OP_AVG) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        x_d     = '0;
                        y_d     = '0;
                        ret_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (xfer) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Simultaneous issue and return leave the in-flight count unchanged.
        case ({xfer, res_acc})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        if (res_acc) begin
            ret_d = ret_q + AW'(1);
        end
    end

    // State and datapath registers; reset aborts any frame and forgets in-flight cells.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
            ret_q   <= '0;
            op_q    <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            out_q   <= out_d;
            ret_q   <= ret_d;
            op_q    <= op_d;
            user_q  <= user_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cell_scan_scheduler.sv
// Directed bench for cell_scan_scheduler on a 5x4 image (3x2 windows), MAX_OUT=2.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later, before the next edge.
// Results are returned by the bench in issue order after a fixed delay or under scenario control.
module tb_cell_scan_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] opcode_i;
    logic [7:0] user_i;
    logic       busy_o, done_o, err_o, cell_valid_o, cell_ready_i;
    logic [2:0] cell_x_o;
    logic [1:0] cell_y_o;
    logic [3:0] cell_op_o;
    logic [7:0] cell_user_o;
    logic       res_valid_i, res_wr_en_o;
    logic [2:0] res_addr_o;

    int checks = 0;
    int errors = 0;

    cell_scan_scheduler #(
        .IMG_W(5), .IMG_H(4), .CELL_N(3), .OPCODE_W(4), .CH_W(8), .MAX_OUT(2)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .opcode_i(opcode_i), .user_i(user_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cell_valid_o(cell_valid_o), .cell_ready_i(cell_ready_i),
        .cell_x_o(cell_x_o), .cell_y_o(cell_y_o), .cell_op_o(cell_op_o), .cell_user_o(cell_user_o),
        .res_valid_i(res_valid_i), .res_wr_en_o(res_wr_en_o), .res_addr_o(res_addr_o)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; opcode_i = '0; user_i = '0;
        cell_ready_i = 1'b0; res_valid_i = 1'b0;
        repeat (3) next_cycle();
        #1;
        checks++;
        if ({busy_o, done_o, err_o, cell_valid_o, res_wr_en_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 00000", {busy_o, done_o, err_o, cell_valid_o, res_wr_en_o});
        end
        checks++;
        if (cell_x_o !== 3'd0 || cell_y_o !== 2'd0 || res_addr_o !== 3'd0) begin
            errors++; $display("FAIL reset_xy_addr: got x=%0d y=%0d addr=%0d exp 0 0 0", cell_x_o, cell_y_o, res_addr_o);
        end
        checks++;
        if (cell_op_o !== 4'd0 || cell_user_o !== 8'd0) begin
            errors++; $display("FAIL reset_op_user: got op=%0d user=%0d exp 0 0", cell_op_o, cell_user_o);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    // Full frame with results returned two cycles after each issue.
    // stall_at: first of three cycles with ready low (-1 none); pulse_at: cycle of a stray start (-1 none).
    task automatic run_stream(input string name, input logic [3:0] op, input logic [7:0] usr,
                              input int stall_at, input int pulse_at);
        int q[$];
        int idx = 0;
        int wr = 0;
        int dones = 0;
        int cyc = 1;
        bit fin = 1'b0;
        next_cycle();
        start_i = 1'b1; opcode_i = op; user_i = usr; cell_ready_i = 1'b1; res_valid_i = 1'b0;
        next_cycle();
        start_i = 1'b0; opcode_i = 4'd0; user_i = 8'd0;
        while (!fin && cyc < 200) begin
            cell_ready_i = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            start_i = (cyc == pulse_at);
            opcode_i = (cyc == pulse_at) ? 4'd7 : 4'd0;
            user_i = (cyc == pulse_at) ? 8'd99 : 8'd0;
            res_valid_i = (q.size() > 0) && (q[0] == cyc);
            #1;
            if (!cell_ready_i) begin
                checks++;
                if (cell_valid_o !== 1'b1 || cell_x_o !== 3'(idx % 3) || cell_y_o !== 2'(idx / 3)) begin
                    errors++;
                    $display("FAIL %s_hold c%0d: got v=%b (%0d,%0d) exp v=1 (%0d,%0d)", name, cyc,
                             cell_valid_o, cell_x_o, cell_y_o, idx % 3, idx / 3);
                end
            end
            if (cell_valid_o && cell_ready_i) begin
                checks++;
                if (idx >= 6 || cell_x_o !== 3'(idx % 3) || cell_y_o !== 2'(idx / 3) ||
                    cell_op_o !== op || cell_user_o !== usr) begin
                    errors++;
                    $display("FAIL %s_issue #%0d: got (%0d,%0d) op=%0d user=%0d exp (%0d,%0d) op=%0d user=%0d",
                             name, idx, cell_x_o, cell_y_o, cell_op_o, cell_user_o, idx % 3, idx / 3, op, usr);
                end
                q.push_back(cyc + 2);
                idx++;
            end
            checks++;
            if (res_wr_en_o !== res_valid_i || (res_valid_i && res_addr_o !== 3'(wr))) begin
                errors++;
                $display("FAIL %s_write c%0d: got en=%b addr=%0d exp en=%b addr=%0d", name, cyc,
                         res_wr_en_o, res_addr_o, res_valid_i, wr);
            end
            if (res_valid_i) begin
                void'(q.pop_front());
                wr++;
            end
            if (done_o) begin
                dones++;
                fin = 1'b1;
                checks++;
                if (err_o !== 1'b0) begin
                    errors++; $display("FAIL %s_err: got %b exp 0", name, err_o);
                end
            end
            next_cycle();
            cyc++;
        end
        start_i = 1'b0; res_valid_i = 1'b0;
        #1;
        checks++;
        if (!fin || idx != 6 || wr != 6 || dones != 1) begin
            errors++;
            $display("FAIL %s_totals: got done=%0d issues=%0d writes=%0d exp 1 6 6", name, dones, idx, wr);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || cell_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got busy=%b done=%b valid=%b exp 0 0 0", name, busy_o, done_o, cell_valid_o);
        end
    endtask

    task automatic test_basic();
        run_stream("basic", 4'd2, 8'd8, -1, -1);
    endtask

    task automatic test_stall();
        run_stream("stall", 4'd2, 8'd8, 2, -1);
    endtask

    task automatic test_start_ignored();
        run_stream("restart", 4'd3, 8'd5, -1, 3);
    endtask

    // Results withheld: issue stops at two in flight; one result frees exactly one more issue.
    task automatic test_withhold();
        bit exp_v [1:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int nx = 0;
        next_cycle();
        start_i = 1'b1; opcode_i = 4'd2; user_i = 8'd1; cell_ready_i = 1'b1; res_valid_i = 1'b0;
        next_cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            res_valid_i = (c == 5);
            #1;
            checks++;
            if (cell_valid_o !== exp_v[c]) begin
                errors++; $display("FAIL withhold_valid c%0d: got %b exp %b", c, cell_valid_o, exp_v[c]);
            end
            if (c == 5) begin
                checks++;
                if (res_wr_en_o !== 1'b1 || res_addr_o !== 3'd0) begin
                    errors++; $display("FAIL withhold_write: got en=%b addr=%0d exp 1 0", res_wr_en_o, res_addr_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (cell_x_o !== 3'd2 || cell_y_o !== 2'd0) begin
                    errors++; $display("FAIL withhold_origin: got (%0d,%0d) exp (2,0)", cell_x_o, cell_y_o);
                end
            end
            if (cell_valid_o && cell_ready_i) nx++;
            next_cycle();
        end
        res_valid_i = 1'b0;
        checks++;
        if (nx != 3) begin
            errors++; $display("FAIL withhold_count: got %0d exp 3", nx);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // Reset while draining aborts at once; a late result must not produce a write.
    task automatic test_reset_drain();
        int xf = 0;
        int rs = 0;
        int cyc = 0;
        next_cycle();
        start_i = 1'b1; opcode_i = 4'd1; user_i = 8'd2; cell_ready_i = 1'b1; res_valid_i = 1'b0;
        next_cycle();
        start_i = 1'b0;
        while (xf < 6 && cyc < 50) begin
            res_valid_i = (xf > rs);
            #1;
            if (res_valid_i) rs++;
            if (cell_valid_o && cell_ready_i) xf++;
            next_cycle();
            cyc++;
        end
        res_valid_i = 1'b0;
        #1;
        checks++;
        if (xf != 6 || busy_o !== 1'b1 || cell_valid_o !== 1'b0) begin
            errors++; $display("FAIL drain_state: got issues=%0d busy=%b valid=%b exp 6 1 0", xf, busy_o, cell_valid_o);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        res_valid_i = 1'b1;
        #1;
        checks++;
        if (res_wr_en_o !== 1'b0 || busy_o !== 1'b0 || cell_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_reset: got wr=%b busy=%b valid=%b done=%b exp 0 0 0 0",
                     res_wr_en_o, busy_o, cell_valid_o, done_o);
        end
        checks++;
        if (res_addr_o !== 3'd0) begin
            errors++; $display("FAIL drain_addr: got %0d exp 0", res_addr_o);
        end
        next_cycle();
        res_valid_i = 1'b0;
    endtask

    task automatic test_invalid();
        next_cycle();
        start_i = 1'b1; opcode_i = 4'd14; user_i = 8'd3; cell_ready_i = 1'b1; res_valid_i = 1'b0;
        #1;
        checks++;
        if (cell_valid_o !== 1'b0) begin
            errors++; $display("FAIL invalid_c0: got valid=%b exp 0", cell_valid_o);
        end
        next_cycle();
        start_i = 1'b0; opcode_i = 4'd0;
        #1;
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || cell_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_done: got done=%b err=%b valid=%b busy=%b exp 1 1 0 0",
                     done_o, err_o, cell_valid_o, busy_o);
        end
        next_cycle();
        #1;
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || cell_valid_o !== 1'b0) begin
            errors++; $display("FAIL invalid_after: got done=%b err=%b valid=%b exp 0 0 0", done_o, err_o, cell_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_withhold();
        test_reset_drain();
        test_invalid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
